led_mode_ctrl: RTL
==================

Name: led_mode_ctrl

Overview:
Output stage and mode controller for the 8-LED bank. It sits directly downstream of the per-mode LED pattern drivers, such as the single-LED heartbeat chaser. It debounces a push-button, cycles the active mode, and holds the pattern drivers in reset for a short blanking window on each mode change. It then multiplexes the selected driver's 8-bit pattern, applies global PWM brightness and pin polarity, and drives the LED pins.

Parameters:
NUM_MODES, 4, number of pattern drivers feeding mode_leds (2..8)
MODE_W, 2, width of mode_sel; must satisfy 2^MODE_W >= NUM_MODES
DEBOUNCE_CYCLES, 1000, clk cycles key must be stable before a change is accepted (>=2)
BLANK_CYCLES, 16, clk cycles of blanking/driver reset after a mode change (>=1)
PWM_BITS, 4, brightness resolution
ACTIVE_LOW, 1, 1 = LED pins active-low (pin 0 = lit)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
key_n  in  1  raw push-button, asynchronous to clk, active-low, bouncy
mode_leds  in  8*NUM_MODES  packed driver patterns; bits [8*i+7:8*i] = mode i, 1 = lit
brightness  in  PWM_BITS  global duty: lit cycles per 2^PWM_BITS cycles
led_pin  out  8  LED pins, registered, polarity per ACTIVE_LOW
mode_sel  out  MODE_W  currently selected mode index
mode_rst_n  out  1  active-low synchronous reset to all pattern drivers; registered
mode_changed  out  1  one-cycle pulse when mode_sel advances

Behaviour:
- Reset (rst_n=0, async):
  - sync flops=1, stable key=1, debounce cnt=0, mode_sel=0, state=BLANK, blank_cnt=0.
  - mode_rst_n=0, mode_changed=0, pwm_cnt=0, bright_q=0.
  - led_pin = all-off: 8'hFF if ACTIVE_LOW, else 8'h00.
- Synchroniser: key_n passes through 2 flops, reset value 1, giving key_s.
- Debounce (counts every cycle):
  - If key_s == stable: cnt=0.
  - Else cnt increments; when cnt == DEBOUNCE_CYCLES-1, stable<=key_s and cnt<=0.
  - Any return of key_s to stable before then clears cnt.
- Press event: stable changes 1->0. Release (0->1) produces no event.
- FSM, 2 states:
  - RUN: on a press event, mode_sel <= (mode_sel==NUM_MODES-1) ? 0 : mode_sel+1. In the same edge: mode_changed<=1, blank_cnt<=0, state<=BLANK.
  - BLANK: blank_cnt increments each cycle. When blank_cnt == BLANK_CYCLES-1, state<=RUN.
  - BLANK: press events are dropped, neither queued nor counted.
  - Blank window length is exactly BLANK_CYCLES cycles.
- mode_rst_n: dedicated flop; equals 1 exactly in cycles where state==RUN.
  - Out of reset, drivers stay in reset for BLANK_CYCLES cycles after rst_n deasserts.
  - Each new mode restarts its pattern from its reset state.
- mode_changed: high for exactly the one cycle following the press-event edge.
- PWM:
  - pwm_cnt: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0.
  - bright_q <= brightness only when pwm_cnt==0; no mid-period duty change.
  - pwm_on = (pwm_cnt < bright_q).
  - brightness 0 gives always off; max value gives (2^PWM_BITS-1)/2^PWM_BITS duty, never 100%.
- Output register:
  - raw = (state==RUN && pwm_on) ? mode_leds[8*mode_sel +: 8] : 8'h00.
  - led_pin <= ACTIVE_LOW ? ~raw : raw.
  - Latency: 1 cycle from mode_leds / pwm_cnt / state to led_pin.
- mode_sel values >= NUM_MODES are unreachable. If forced, select mode 0 pattern.
- Reset mid-BLANK or mid-debounce: all state returns to reset values immediately; mode_sel returns to 0.

Test Plan:
All cases use DEBOUNCE_CYCLES=8, BLANK_CYCLES=16, PWM_BITS=4, ACTIVE_LOW=1, NUM_MODES=4.
1. Reset, then hold key_n=1 and brightness=15 -> led_pin=FF, mode_rst_n=0 for 16 cycles after rst_n rises, then 1. mode_sel=0. mode_changed never pulses.
2. key_n low pulses of 3 cycles, separated by 3 high cycles, repeated 10 times -> no stable change, mode_sel stays 0, mode_changed stays 0.
3. key_n held low 20 cycles -> exactly one mode_changed pulse, mode_sel=1, mode_rst_n low exactly 16 cycles, led_pin=FF throughout blank.
4. Four clean presses (each with release), waiting out blank each time -> mode_sel sequence 1,2,3,0 (wrap).
5. Second clean press landing inside the blank window -> ignored; mode_sel advances only once.
6. mode_leds mode 0 = 8'h01, brightness=8 -> per 16-cycle period led_pin=FE for 8 cycles, FF for 8. brightness=0 -> always FF. Change brightness mid-period -> duty changes only at next pwm_cnt==0.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// LED bank output stage: debounced mode button, blanking reset to the pattern
// drivers on mode change, pattern mux, global PWM dimming and pin polarity.
module led_mode_ctrl #(
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BLANK_CYCLES    = 16,
  parameter int PWM_BITS        = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_n,
  input  logic [8*NUM_MODES-1:0] mode_leds,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [7:0]             led_pin,
  output logic [MODE_W-1:0]      mode_sel,
  output logic                   mode_rst_n,
  output logic                   mode_changed
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLANK_CYCLES - 1);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [7:0]        LED_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {S_RUN, S_BLANK} state_e;

  logic [1:0]          key_sync_q;
  logic                stable_q;
  logic [DB_W-1:0]     db_cnt_q;
  state_e              state_q;
  logic [BL_W-1:0]     blank_cnt_q;
  logic [MODE_W-1:0]   mode_sel_q;
  logic                mode_rst_n_q;
  logic                mode_changed_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] bright_q;
  logic [7:0]          led_pin_q;

  logic       key_s;
  logic       press_d;
  logic       pwm_on;
  logic [7:0] pat_d;
  logic [7:0] raw_d;
  logic [7:0] led_d;

  assign key_s = key_sync_q[1];
  // Press is recognised on the same edge that commits stable 1->0.
  assign press_d = stable_q & ~key_s & (db_cnt_q == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_q <= 2'b11;
      stable_q   <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      key_sync_q <= {key_sync_q[0], key_n};
      if (key_s == stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_q <= key_s;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_BLANK;
      blank_cnt_q    <= '0;
      mode_sel_q     <= '0;
      mode_rst_n_q   <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_changed_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          mode_rst_n_q <= 1'b1;
          if (press_d) begin
            mode_sel_q     <= (mode_sel_q == LAST_MODE) ? '0 : mode_sel_q + MODE_W'(1);
            mode_changed_q <= 1'b1;
            blank_cnt_q    <= '0;
            state_q        <= S_BLANK;
            mode_rst_n_q   <= 1'b0;
          end
        end
        default: begin
          // Presses arriving here are dropped; the drivers stay in reset.
          blank_cnt_q  <= blank_cnt_q + BL_W'(1);
          mode_rst_n_q <= 1'b0;
          if (blank_cnt_q == BL_LAST) begin
            state_q      <= S_RUN;
            mode_rst_n_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      bright_q  <= '0;
      led_pin_q <= LED_OFF;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == '0) bright_q <= brightness;
      led_pin_q <= led_d;
    end
  end

  assign pwm_on = (pwm_cnt_q < bright_q);

  // Out-of-range selects fall back to the mode 0 pattern.
  always_comb begin
    pat_d = mode_leds[7:0];
    for (int i = 1; i < NUM_MODES; i++) begin
      if (mode_sel_q == MODE_W'(i)) pat_d = mode_leds[8*i +: 8];
    end
    raw_d = (state_q == S_RUN && pwm_on) ? pat_d : 8'h00;
    led_d = ACTIVE_LOW ? ~raw_d : raw_d;
  end

  assign led_pin      = led_pin_q;
  assign mode_sel     = mode_sel_q;
  assign mode_rst_n   = mode_rst_n_q;
  assign mode_changed = mode_changed_q;

endmodule
